int_request_arbiter: RTL and testbench

INT_REQUEST_ARBITER -- requirements
Module: int_request_arbiter

---
 rtl/int_request_arbiter.sv | 128 ++++++++++++
 tb/tb_int_request_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/int_request_arbiter.sv
// int_request_arbiter: latches one-cycle interrupt request pulses from NUM_SRC
// sources and hands them one at a time to an interrupt controller. The next
// source is chosen round-robin, starting just after the last source served.
// It counts requests that arrive while the same source is already pending
// (ovf_cnt, saturating at 255).
// Optional feature: define INT_REQUEST_ARBITER_MASK_EN to add the src_mask
// port. A masked source still latches and counts, but is never selected.
module int_request_arbiter #(
  parameter int          NUM_SRC     = 8,
  parameter logic [7:0]  VECTOR_BASE = 8'h00
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SRC-1:0] src_irq,
`ifdef INT_REQUEST_ARBITER_MASK_EN
  input  logic [NUM_SRC-1:0] src_mask,
`endif
  output logic [NUM_SRC-1:0] src_ack,
  output logic [NUM_SRC-1:0] pending,
  output logic [7:0]         ovf_cnt,
  output logic               int_valid,
  output logic [7:0]         int_vector,
  input  logic               int_done
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, CLR} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, ack_q, eligible, clr_mask, merged;
  logic [7:0]         ovf_q, ovf_d, vector_q;
  logic               valid_q, found;
  logic [IDX_W-1:0]   sel_q, rr_ptr_q, pick;
  logic               done_now;

  // A completion is only honoured while a request is outstanding.
  assign done_now = (state_q == REQ) && int_done;

  // Work out which sources can be selected, what clears this cycle, and what merges.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    clr_mask = '0;
`ifdef INT_REQUEST_ARBITER_MASK_EN
    eligible = pending_q & ~src_mask;
`else
    eligible = pending_q;
`endif
    if (done_now) clr_mask[sel_q] = 1'b1;
    // A new pulse on the bit being cleared counts as a fresh request, not a merge.
    merged = src_irq & pending_q & ~clr_mask;
  end

  // Find the first eligible source, searching upward from rr_ptr and wrapping to 0.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  // Add this cycle's merges to the overflow count, saturating at 255.
  always_comb begin
    int ovf_sum;
    ovf_sum = int'(ovf_q) + $countones(merged);
    ovf_d   = (ovf_sum > 255) ? 8'hFF : 8'(ovf_sum);
  end

  // Next-state logic: IDLE -> REQ on a selection, REQ -> CLR on done, CLR -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = REQ;
      REQ:     if (int_done) state_d = CLR;
      CLR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath registers: pending bits, the selection, round-robin pointer, outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pending_q <= '0;
      ack_q     <= '0;
      ovf_q     <= '0;
      valid_q   <= 1'b0;
      vector_q  <= '0;
      sel_q     <= '0;
      rr_ptr_q  <= '0;
    end else begin
      // A set wins over a clear on the same bit.
      pending_q <= (pending_q & ~clr_mask) | src_irq;
      ovf_q     <= ovf_d;
      ack_q     <= clr_mask;
      if (state_q == IDLE && found) begin
        sel_q    <= pick;
        valid_q  <= 1'b1;
        vector_q <= VECTOR_BASE + 8'(pick);
      end
      if (done_now) begin
        valid_q  <= 1'b0;
        rr_ptr_q <= (sel_q == IDX_W'(NUM_SRC - 1)) ? '0 : sel_q + 1'b1;
      end
    end
  end

  assign pending    = pending_q;
  assign src_ack    = ack_q;
  assign ovf_cnt    = ovf_q;
  assign int_valid  = valid_q;
  assign int_vector = vector_q;

endmodule

// File: tb/tb_int_request_arbiter.sv
// Self-checking bench for int_request_arbiter (NUM_SRC=8, VECTOR_BASE=0x20).
// It first runs a table of single-cycle vectors, then hand-written
// multi-cycle sequences: full round robin, overflow saturation,
// set-over-clear priority, reset during a request, and masking when
// INT_REQUEST_ARBITER_MASK_EN is defined.
module tb_int_request_arbiter;

  localparam int         N    = 8;
  localparam logic [7:0] BASE = 8'h20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] src_irq = '0;
  logic         int_done = 1'b0;
  logic [N-1:0] src_ack, pending;
  logic [7:0]   ovf_cnt, int_vector;
  logic         int_valid;
`ifdef INT_REQUEST_ARBITER_MASK_EN
  logic [N-1:0] src_mask = '0;
`endif

  int n_vec = 0;
  int n_err = 0;

  int_request_arbiter #(.NUM_SRC(N), .VECTOR_BASE(BASE)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .src_irq    (src_irq),
`ifdef INT_REQUEST_ARBITER_MASK_EN
    .src_mask   (src_mask),
`endif
    .src_ack    (src_ack),
    .pending    (pending),
    .ovf_cnt    (ovf_cnt),
    .int_valid  (int_valid),
    .int_vector (int_vector),
    .int_done   (int_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [7:0] irq;
    logic       done;
    logic       exp_valid;
    logic [7:0] exp_vec;
    logic [7:0] exp_pend;
    logic [7:0] exp_ack;
    logic [7:0] exp_ovf;
  } vec_t;

  vec_t tbl [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Wait up to 10 cycles for int_valid. Running out of cycles counts as a failure.
  task automatic wait_valid();
    for (int i = 0; i < 10; i++) begin
      if (int_valid) break;
      tick();
    end
    check("wait_valid", 32'(int_valid), 32'd1);
  endtask

  // Deliver one interrupt: expect source src, answer int_done 3 cycles later, expect the ack.
  task automatic deliver(input int src);
    wait_valid();
    check($sformatf("vector_src%0d", src), 32'(int_vector), 32'(BASE + 8'(src)));
    tick();
    tick();
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
    check($sformatf("ack_src%0d", src), 32'(src_ack), 32'(8'h01 << src));
    check($sformatf("valid_low_src%0d", src), 32'(int_valid), 32'd0);
  endtask

  initial begin
    int cnt;
    // Fields: rst_n, irq, done, exp valid, exp vector, exp pending, exp ack, exp ovf.
    tbl[0]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00}; // irq ignored in reset
    tbl[1]  = '{1'b1, 8'h08, 1'b0, 1'b0, 8'h00, 8'h08, 8'h00, 8'h00}; // latch src 3
    tbl[2]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h23, 8'h08, 8'h00, 8'h00}; // valid two cycles on
    tbl[3]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h23, 8'h08, 8'h00, 8'h00}; // held
    tbl[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h23, 8'h00, 8'h08, 8'h00}; // done -> ack 3
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h23, 8'h00, 8'h00, 8'h00}; // ack is one pulse
    tbl[6]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h23, 8'h00, 8'h00, 8'h00}; // done in IDLE ignored
    tbl[7]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h23, 8'h02, 8'h00, 8'h00}; // latch src 1
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h21, 8'h02, 8'h00, 8'h00}; // wrap from rr_ptr 4
    tbl[9]  = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h21, 8'h02, 8'h00, 8'h01}; // merge -> ovf 1
    tbl[10] = '{1'b1, 8'h02, 1'b1, 1'b0, 8'h21, 8'h02, 8'h02, 8'h01}; // set wins over clear
    tbl[11] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h21, 8'h02, 8'h00, 8'h01}; // CLR
    tbl[12] = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h21, 8'h02, 8'h00, 8'h01}; // re-request src 1
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00}; // reset in REQ
    tbl[14] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[15] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};

    tick();
    for (int i = 0; i < 16; i++) begin
      rst_n    = tbl[i].rst_n;
      src_irq  = tbl[i].irq;
      int_done = tbl[i].done;
      tick();
      check($sformatf("tbl%0d_valid", i),  32'(int_valid),  32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_vector", i), 32'(int_vector), 32'(tbl[i].exp_vec));
      check($sformatf("tbl%0d_pending", i), 32'(pending),   32'(tbl[i].exp_pend));
      check($sformatf("tbl%0d_ack", i),    32'(src_ack),    32'(tbl[i].exp_ack));
      check($sformatf("tbl%0d_ovf", i),    32'(ovf_cnt),    32'(tbl[i].exp_ovf));
    end
    src_irq  = '0;
    int_done = 1'b0;

    // All eight sources at once: served 0..7 in order with no overflow.
    do_reset();
    src_irq = 8'hFF;
    tick();
    src_irq = '0;
    for (int s = 0; s < N; s++) deliver(s);
    check("rr_all_pending", 32'(pending), 32'd0);
    check("rr_all_ovf", 32'(ovf_cnt), 32'd0);

    // 300 merged pulses on src 5: the count saturates, and src 5 is delivered only once.
    do_reset();
    src_irq = 8'h20;
    tick();
    for (int i = 0; i < 300; i++) tick();
    src_irq = '0;
    check("sat_ovf", 32'(ovf_cnt), 32'd255);
    deliver(5);
    check("sat_pending", 32'(pending), 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (int_valid) cnt++;
    end
    check("sat_no_redelivery", 32'(cnt), 32'd0);
    check("sat_ovf_hold", 32'(ovf_cnt), 32'd255);

    // src 2 pulses again on its own clear cycle: it stays pending and is served last.
    do_reset();
    src_irq = 8'h04;
    tick();
    src_irq = '0;
    wait_valid();
    check("prio_vector", 32'(int_vector), 32'h22);
    src_irq = 8'hFB;
    tick();
    src_irq  = 8'h04;
    int_done = 1'b1;
    tick();
    src_irq  = '0;
    int_done = 1'b0;
    check("prio_ack", 32'(src_ack), 32'h04);
    check("prio_pending", 32'(pending), 32'hFF);
    check("prio_ovf", 32'(ovf_cnt), 32'd0);
    for (int k = 0; k < N; k++) deliver((3 + k) % N);
    check("prio_drained", 32'(pending), 32'd0);

    // One cycle of reset during REQ with pending=0x11 abandons everything.
    do_reset();
    src_irq = 8'h11;
    tick();
    src_irq = '0;
    wait_valid();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_valid", 32'(int_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_vector", 32'(int_vector), 32'd0);
    check("rst_ovf", 32'(ovf_cnt), 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (int_valid || (src_ack != '0)) cnt++;
      tick();
    end
    check("rst_quiet", 32'(cnt), 32'd0);

`ifdef INT_REQUEST_ARBITER_MASK_EN
    // src 0 is masked, so only src 1 is delivered; after unmasking, src 0 follows.
    do_reset();
    src_mask = 8'h01;
    src_irq  = 8'h03;
    tick();
    src_irq = '0;
    deliver(1);
    for (int i = 0; i < 4; i++) tick();
    check("mask_hold_valid", 32'(int_valid), 32'd0);
    check("mask_hold_pending", 32'(pending), 32'h01);
    src_mask = 8'h00;
    deliver(0);
    check("mask_pending", 32'(pending), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
